// File: rtl/word_bcast_buff.sv
// Serial-bit to word converter feeding a small output FIFO.
// Broadcast mode replicates each accepted bit across a whole word; collect mode
// assembles WIDTH bits LSB first and pushes the finished word.
module word_bcast_buff #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic             mode,
   output logic [WIDTH-1:0] o,
   output logic             o_valid,
   input  logic             o_ready,
   output logic             busy
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam int unsigned PW = $clog2(DEPTH);

   localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CntOne  = CW'(1);
   localparam logic [PW-1:0] PtrOne  = PW'(1);
   localparam logic [PW:0]   OccOne  = (PW + 1)'(1);
   localparam logic [PW:0]   OccFull = (PW + 1)'(DEPTH);

   typedef enum logic {StIdle, StCollect} state_e;

   state_e           state;
   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-1:0] shreg;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic [PW:0]      count;

   logic             full;
   logic             empty;
   logic             accept;
   logic             push_en;
   logic             pop_en;
   logic [WIDTH-1:0] word_next;
   logic [WIDTH-1:0] push_data;

   assign full    = (count == OccFull);
   assign empty   = (count == '0);
   // a_ready depends only on registered occupancy and reset, never on o_ready
   assign a_ready = !full && !rst;
   assign accept  = a_valid && a_ready;
   assign push_en = accept && (!mode || (bit_cnt == LastBit));
   assign o_valid = !empty;
   assign pop_en  = o_valid && o_ready;
   assign o       = empty ? '0 : mem[rptr];
   // StCollect holds exactly when bit_cnt is non-zero
   assign busy    = (state == StCollect) || !empty;

   // Collector word with the incoming bit placed at the current position
   always_comb begin
      word_next          = shreg;
      word_next[bit_cnt] = a;
      push_data          = mode ? word_next : {WIDTH{a}};
   end

   // Collector FSM: bit counter and partial-word register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= StIdle;
         bit_cnt <= '0;
         shreg   <= '0;
      end else if (accept) begin
         if (!mode || (bit_cnt == LastBit)) begin
            // broadcast drops any partial word; completion starts a fresh one
            state   <= StIdle;
            bit_cnt <= '0;
            shreg   <= '0;
         end else begin
            state   <= StCollect;
            bit_cnt <= bit_cnt + CntOne;
            shreg   <= word_next;
         end
      end
   end

   // FIFO storage; contents need no reset since occupancy gates visibility
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem[wptr] <= push_data;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_en) begin
            wptr <= wptr + PtrOne;
         end
         if (pop_en) begin
            rptr <= rptr + PtrOne;
         end
         if (push_en && !pop_en) begin
            count <= count + OccOne;
         end else if (pop_en && !push_en) begin
            count <= count - OccOne;
         end
      end
   end

endmodule
